// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - data-memory port A request/response bundle
interface uart_tx_mmio_if;
   logic [1:0]  weA;
   logic [2:0]  reA;
   logic [31:0] addrA;
   logic [31:0] dinA;
   logic [31:0] doutA;

   modport master (output weA, output reA, output addrA, output dinA, input doutA);
   modport slave  (input weA, input reA, input addrA, input dinA, output doutA);
endinterface

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with a small TX FIFO
module uart_tx_mmio #(
   parameter int          CLK_FREQ   = 66000000,
   parameter int          BAUD_RATE  = 115200,
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFF0,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_mmio_if.slave  bus,
   output logic           uart_tx,
   output logic           tx_busy
);
   localparam int CPB   = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
   localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

   generate
      if (CPB < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
          BASE_ADDR[3:0] != 4'h0) begin : g_bad_params
         $error("uart_tx_mmio: invalid parameters");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             overflow;

   logic        sel, wr_any, push_req, stat_wr, push_ok, pop;
   logic        full, empty, bit_end;
   logic [1:0]  reg_sel;
   logic [31:0] status, rd_val, shifted, rd_data;
   logic        unused_dina;

   assign sel      = (bus.addrA[31:4] == BASE_ADDR[31:4]);
   assign reg_sel  = bus.addrA[3:2];
   assign wr_any   = sel && (bus.weA != 2'b00);
   assign push_req = wr_any && (reg_sel == 2'd0);
   assign stat_wr  = wr_any && (reg_sel == 2'd1);
   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign bit_end  = (cnt == CNT_LAST);
   // Popping at the last STOP cycle keeps back-to-back frames contiguous.
   assign pop      = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
   assign push_ok  = push_req && (!full || pop);
   assign tx_busy  = (state != S_IDLE) || !empty;
   assign unused_dina = ^bus.dinA[31:8];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= bus.dinA[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (stat_wr)
            overflow <= 1'b0;
         else if (push_req && !push_ok)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         uart_tx <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  shreg   <= mem[rd_ptr];
                  cnt     <= '0;
                  state   <= S_START;
                  uart_tx <= 1'b0;
               end
            end
            S_START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= S_DATA;
                  uart_tx <= shreg[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= S_STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= {1'b0, shreg[7:1]};
                     uart_tx <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (pop) begin
                     shreg   <= mem[rd_ptr];
                     state   <= S_START;
                     uart_tx <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               uart_tx <= 1'b1;
            end
         endcase
      end
   end

   // Reads see register state before any write on the same edge.
   assign status  = {28'd0, overflow, empty, full, tx_busy};
   assign rd_val  = (reg_sel == 2'd1) ? status : 32'd0;
   assign shifted = rd_val >> {bus.addrA[1:0], 3'b000};

   always_comb begin
      rd_data = 32'd0;
      case (bus.reA[1:0])
         2'b01:   rd_data = {{24{bus.reA[2] & shifted[7]}}, shifted[7:0]};
         2'b10:   rd_data = {{16{bus.reA[2] & shifted[15]}}, shifted[15:0]};
         2'b11:   rd_data = shifted;
         default: rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         bus.doutA <= 32'd0;
      else if (sel && bus.reA[1:0] != 2'b00)
         bus.doutA <= rd_data;
      else
         bus.doutA <= 32'd0;
   end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio (CPB=8, depth 4)
module tb_uart_tx_mmio;
   localparam int          CPB  = 8;
   localparam logic [31:0] BASE = 32'hFFFF_FFF0;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic uart_tx, tx_busy;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   rx_en = 1'b0;

   logic [7:0] exp_q [$];
   int         start_q [$];
   logic [7:0] rx_b;
   int         rx_t0;
   logic [31:0] d;

   typedef struct {
      logic [1:0]  we;
      logic [2:0]  re;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [15];

   uart_tx_mmio_if bus ();

   uart_tx_mmio #(
      .CLK_FREQ   (8),
      .BAUD_RATE  (1),
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (4)
   ) dut (
      .clk     (clk),
      .rst     (rst_n),
      .bus     (bus),
      .uart_tx (uart_tx),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One request per call, captured on the next rising edge.
   task automatic req(input logic [1:0] we, input logic [2:0] re, input logic [31:0] addr,
                      input logic [31:0] din, output logic [31:0] dout);
      @(negedge clk);
      bus.weA   = we;
      bus.reA   = re;
      bus.addrA = addr;
      bus.dinA  = din;
      @(posedge clk);
      #1;
      dout    = bus.doutA;
      bus.weA = 2'b00;
      bus.reA = 3'b000;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (tx_busy && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("idle_timeout", tx_busy, 1'b0);
      repeat (4) @(posedge clk);
   endtask

   // Serial receiver: samples mid-bit and pops the scoreboard per frame.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_en && rst_n && uart_tx === 1'b0) begin
            rx_t0 = cyc;
            repeat (CPB / 2 - 1) @(negedge clk);
            chk("rx_start", uart_tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               rx_b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            chk("rx_stop", uart_tx, 1'b1);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rx_unexpected: got byte 0x%02h required none", rx_b);
            end else begin
               chk("rx_byte", rx_b, exp_q.pop_front());
            end
            start_q.push_back(rx_t0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fb [10];
      logic [7:0] frame;

      bus.weA = 2'b00; bus.reA = 3'b000; bus.addrA = 32'd0; bus.dinA = 32'd0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", bus.doutA, 32'd0);
      chk("rst_tx", uart_tx, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("idle_tx", uart_tx, 1'b1);
      chk("idle_busy", tx_busy, 1'b0);
      rx_en = 1'b1;

      tbl[0]  = '{2'b00, 3'b011, BASE + 32'h4, 32'h0,  32'h4};
      tbl[1]  = '{2'b00, 3'b001, BASE + 32'h4, 32'h0,  32'h4};
      tbl[2]  = '{2'b00, 3'b010, BASE + 32'h4, 32'h0,  32'h4};
      tbl[3]  = '{2'b00, 3'b101, BASE + 32'h4, 32'h0,  32'h4};
      tbl[4]  = '{2'b00, 3'b001, BASE + 32'h5, 32'h0,  32'h0};
      tbl[5]  = '{2'b00, 3'b000, BASE + 32'h4, 32'h0,  32'h0};
      tbl[6]  = '{2'b00, 3'b011, BASE + 32'h0, 32'h0,  32'h0};
      tbl[7]  = '{2'b00, 3'b011, BASE + 32'h8, 32'h0,  32'h0};
      tbl[8]  = '{2'b00, 3'b011, BASE + 32'hC, 32'h0,  32'h0};
      tbl[9]  = '{2'b00, 3'b011, 32'h0000_0004, 32'h0, 32'h0};
      tbl[10] = '{2'b00, 3'b011, 32'hFFFF_FFE4, 32'h0, 32'h0};
      tbl[11] = '{2'b11, 3'b000, BASE + 32'h8, 32'h55, 32'h0};
      tbl[12] = '{2'b01, 3'b000, 32'h1234_5670, 32'h77, 32'h0};
      tbl[13] = '{2'b11, 3'b011, BASE + 32'h4, 32'h0,  32'h4};
      tbl[14] = '{2'b00, 3'b011, BASE + 32'h4, 32'h0,  32'h4};
      for (int i = 0; i < 15; i++) begin
         req(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].din, d);
         chk($sformatf("vec%0d", i), d, tbl[i].exp);
      end
      chk("vec_tx", uart_tx, 1'b1);

      // Single byte: exact frame timing against the write edge.
      frame = 8'hA5;
      fb[0] = 8'd0;
      for (int b = 0; b < 8; b++) fb[b + 1] = {7'd0, frame[b]};
      fb[9] = 8'd1;
      exp_q.push_back(frame);
      req(2'b01, 3'b000, BASE, 32'h0000_00A5, d);
      chk("sb_tx_n", uart_tx, 1'b1);
      chk("sb_busy_n", tx_busy, 1'b1);
      for (int k = 1; k <= 81; k++) begin
         @(posedge clk);
         #1;
         if (k <= 80) begin
            chk($sformatf("sb_bit_k%0d", k), uart_tx, fb[(k - 1) / CPB][0]);
            if (k == 80) chk("sb_busy_last", tx_busy, 1'b1);
         end else begin
            chk("sb_busy_end", tx_busy, 1'b0);
            chk("sb_tx_end", uart_tx, 1'b1);
         end
      end
      repeat (4) @(posedge clk);

      // Overflow: six back-to-back byte writes, the sixth is dropped.
      start_q.delete();
      for (int i = 0; i < 6; i++) begin
         if (i < 5) exp_q.push_back(8'h11 + 8'(i));
         req(2'b01, 3'b000, BASE, 32'h11 + i, d);
      end
      req(2'b00, 3'b011, BASE + 32'h4, 32'h0, d);
      chk("ovf_status", d, 32'hB);
      repeat (90) @(posedge clk);
      req(2'b00, 3'b101, BASE + 32'h4, 32'h0, d);
      chk("lb_status", d, 32'h9);
      req(2'b00, 3'b010, BASE + 32'hA, 32'h0, d);
      chk("lh_reserved", d, 32'h0);
      req(2'b11, 3'b011, BASE + 32'h4, 32'h0, d);
      chk("wr_rd_prewrite", d, 32'h9);
      req(2'b00, 3'b011, BASE + 32'h4, 32'h0, d);
      chk("ovf_cleared", d, 32'h1);
      wait_idle(600);
      chk("gap_count", start_q.size(), 32'd5);
      for (int i = 1; i < start_q.size(); i++)
         chk($sformatf("gap%0d", i), start_q[i] - start_q[i - 1], 32'd80);

      // Full FIFO with a push coinciding with the end-of-STOP pop.
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(8'h21 + 8'(i));
         req(2'b01, 3'b000, BASE, 32'h21 + i, d);
      end
      repeat (73) @(posedge clk);
      req(2'b00, 3'b011, BASE + 32'h4, 32'h0, d);
      chk("full_status", d, 32'h3);
      repeat (2) @(posedge clk);
      exp_q.push_back(8'h26);
      req(2'b01, 3'b000, BASE, 32'h26, d);
      req(2'b00, 3'b011, BASE + 32'h4, 32'h0, d);
      chk("pushpop_status", d, 32'h3);
      wait_idle(600);

      // Asynchronous reset during data bit 3 of 0xF0 (a zero bit).
      rx_en = 1'b0;
      req(2'b01, 3'b000, BASE, 32'hF0, d);
      repeat (36) @(posedge clk);
      #2;
      chk("ar_pre_tx", uart_tx, 1'b0);
      chk("ar_pre_busy", tx_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("ar_tx", uart_tx, 1'b1);
      chk("ar_busy", tx_busy, 1'b0);
      chk("ar_dout", bus.doutA, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("ar_quiet%0d", k), uart_tx, 1'b1);
      end
      req(2'b00, 3'b011, BASE + 32'h4, 32'h0, d);
      chk("ar_status", d, 32'h4);
      rx_en = 1'b1;

      repeat (10) @(posedge clk);
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
